rgb_gray_pipe: RTL

//  Parametrised, pipelined successor to the RGB-to-grayscale converter.
//  - Accepts one RGB pixel per cycle over a valid/ready stream.
//  - Converts it with a per-pixel selectable mode: passthrough, BT.601 luma, average, or custom weights.
//  - Drives the gray result on all three output channels, with fixed latency and full backpressure.
//  - Sits between pixel source and frame sink in the video datapath.

---
 rtl/rgb_gray_pipe.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/rgb_gray_pipe.sv
// Three-stage RGB-to-gray converter with per-pixel mode and weights.
// Stages: S1 multiply, S2 sum, S3 round/saturate. A single advance signal stalls the whole pipe.

module rgb_gray_lane #(
   parameter int DATA_W = 8,
   parameter int COEF_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     adv,
   input  logic [DATA_W-1:0]        din,
   input  logic [COEF_W-1:0]        coef,
   output logic [DATA_W+COEF_W-1:0] prod,
   output logic [DATA_W-1:0]        dly
);
   localparam int PW = DATA_W + COEF_W;

   logic [DATA_W-1:0] d1;

   // The raw channel rides alongside the product so pass mode can bypass the math.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prod <= '0;
         d1   <= '0;
         dly  <= '0;
      end else if (adv) begin
         prod <= PW'(din) * PW'(coef);
         d1   <= din;
         dly  <= d1;
      end
   end
endmodule

module rgb_gray_pipe #(
   parameter int DATA_W = 8,
   parameter int COEF_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              InValid,
   output logic              InReady,
   input  logic [1:0]        Mode,
   input  logic              InLast,
   input  logic [DATA_W-1:0] Red,
   input  logic [DATA_W-1:0] Green,
   input  logic [DATA_W-1:0] Blue,
   input  logic [COEF_W-1:0] CoefR,
   input  logic [COEF_W-1:0] CoefG,
   input  logic [COEF_W-1:0] CoefB,
   output logic              OutValid,
   input  logic              OutReady,
   output logic [DATA_W-1:0] RedOut,
   output logic [DATA_W-1:0] GreenOut,
   output logic [DATA_W-1:0] BlueOut,
   output logic              OutLast,
   output logic              OutSat
);
   localparam int NUM_LANES = 3;
   localparam int STAGES    = 3;
   localparam int PW        = DATA_W + COEF_W;
   localparam int SW        = DATA_W + COEF_W + 2;

   localparam logic [1:0] M_PASS = 2'b00;
   localparam logic [1:0] M_LUMA = 2'b01;
   localparam logic [1:0] M_AVG  = 2'b10;
   localparam logic [1:0] M_CUST = 2'b11;

   localparam logic [COEF_W-1:0] LUMA_R = COEF_W'(77)  << (COEF_W - 8);
   localparam logic [COEF_W-1:0] LUMA_G = COEF_W'(150) << (COEF_W - 8);
   localparam logic [COEF_W-1:0] LUMA_B = COEF_W'(29)  << (COEF_W - 8);
   localparam logic [COEF_W-1:0] AVG_RB = COEF_W'(85);
   localparam logic [COEF_W-1:0] AVG_G  = COEF_W'(86);
   localparam logic [SW-1:0]     HALF   = SW'(1) << (COEF_W - 1);

   typedef struct packed {
      logic [1:0] mode;
      logic       last;
   } side_t;

   logic                                  adv;
   logic [STAGES:1]                       vld_pipe;
   side_t                                 side1, side2;
   logic [NUM_LANES-1:0][DATA_W-1:0]      pix, pix2;
   logic [NUM_LANES-1:0][COEF_W-1:0]      coef_sel;
   logic [NUM_LANES-1:0][PW-1:0]          prod1;
   logic [SW-1:0]                         sum2, rnd;
   logic [DATA_W+1:0]                     res;
   logic [DATA_W-1:0]                     gray;
   logic                                  sat;

   // Output register empty or draining: every stage may move.
   assign adv      = !vld_pipe[STAGES] | OutReady;
   assign InReady  = adv;
   assign OutValid = vld_pipe[STAGES];
   assign pix      = {Blue, Green, Red};

   always_comb begin
      coef_sel = '0;
      unique case (Mode)
         M_PASS: coef_sel = '0;
         M_LUMA: coef_sel = {LUMA_B, LUMA_G, LUMA_R};
         M_AVG:  coef_sel = {AVG_RB, AVG_G, AVG_RB};
         M_CUST: coef_sel = {CoefB, CoefG, CoefR};
      endcase
   end

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      rgb_gray_lane #(.DATA_W(DATA_W), .COEF_W(COEF_W)) u_lane (
         .clk  (clk),
         .rst  (rst),
         .adv  (adv),
         .din  (pix[l]),
         .coef (coef_sel[l]),
         .prod (prod1[l]),
         .dly  (pix2[l])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe <= '0;
         side1    <= '0;
         side2    <= '0;
         sum2     <= '0;
      end else if (adv) begin
         vld_pipe <= {vld_pipe[STAGES-1:1], InValid};
         side1    <= '{mode: Mode, last: InLast};
         side2    <= side1;
         sum2     <= SW'(prod1[0]) + SW'(prod1[1]) + SW'(prod1[2]);
      end
   end

   assign rnd  = sum2 + HALF;
   assign res  = rnd[SW-1:COEF_W];
   assign sat  = |res[DATA_W+1:DATA_W];
   assign gray = sat ? '1 : res[DATA_W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         RedOut   <= '0;
         GreenOut <= '0;
         BlueOut  <= '0;
         OutLast  <= 1'b0;
         OutSat   <= 1'b0;
      end else if (adv) begin
         OutLast <= side2.last;
         if (side2.mode == M_PASS) begin
            RedOut   <= pix2[0];
            GreenOut <= pix2[1];
            BlueOut  <= pix2[2];
            OutSat   <= 1'b0;
         end else begin
            RedOut   <= gray;
            GreenOut <= gray;
            BlueOut  <= gray;
            OutSat   <= sat;
         end
      end
   end
endmodule
